// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory-access pipeline stage (execute -> memory -> writeback)
//
// Purpose
//   Latches the execute-stage bus, captures the synchronous data-SRAM read
//   data (holding it while writeback stalls), aligns and extends load data,
//   forwards results / exception / ertn status upstream and presents a packed
//   bus to writeback.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   EXE_to_MEM_BUS     execute-stage bus (IN_LEN bits)
//   EXE_to_MEM_valid   upstream valid
//   MEM_allowin        this stage can accept a new entry
//   WB_allowin         writeback can accept
//   MEM_to_WB_valid    valid towards writeback
//   MEM_to_WB_BUS      packed bus to writeback (OUT_LEN bits)
//   MEM_RF_BUS         forwarding bus to decode (FWD_LEN bits)
//   data_sram_rdata    SRAM read data, valid the cycle after the request
//   mem_ex, mem_ertn   exception / ertn present in this stage
//   ertn_flush, wb_ex  flushes from writeback
//   perf_ld_cnt        retired loads (0 unless MEM_PERF_CNT_EN)
//   perf_stall_cnt     stalled cycles holding a load (0 unless MEM_PERF_CNT_EN)
//
// Configuration
//   MEM_PERF_CNT_EN    define to build the two performance counters
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int IN_LEN  = 205,
    parameter int OUT_LEN = 166,
    parameter int FWD_LEN = 54
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [IN_LEN-1:0]  EXE_to_MEM_BUS,
    input  logic               EXE_to_MEM_valid,
    output logic               MEM_allowin,
    input  logic               WB_allowin,
    output logic               MEM_to_WB_valid,
    output logic [OUT_LEN-1:0] MEM_to_WB_BUS,
    output logic [FWD_LEN-1:0] MEM_RF_BUS,
    input  logic [31:0]        data_sram_rdata,
    output logic               mem_ex,
    output logic               mem_ertn,
    input  logic               ertn_flush,
    input  logic               wb_ex,
    output logic [31:0]        perf_ld_cnt,
    output logic [31:0]        perf_stall_cnt
);

    logic              mem_valid_q, mem_valid_d;
    logic [IN_LEN-1:0] bus_q, bus_d;
    logic              first_q, first_d;
    logic              hold_vld_q, hold_vld_d;
    logic [31:0]       rdata_hold_q, rdata_hold_d;

    logic        flush, entry;
    logic [31:0] rdata, load_value, final_result;

    // Fields of the latched execute bus
    logic [31:0] pc, exe_result, st_data, csr_wvalue, csr_wmask;
    logic [13:0] csr_num;
    logic [14:0] ex_code;
    logic [4:0]  dest, load_op;
    logic        gr_we, mem_en, rfrom_mem, csr_we, ex, inst_ertn;

    assign {pc, gr_we, dest, exe_result, st_data, mem_en, load_op, rfrom_mem,
            csr_num, csr_we, csr_wvalue, csr_wmask, ex, ex_code, inst_ertn} = bus_q;

    // Store data and the request enable were consumed by the execute stage.
    logic unused_fields;
    assign unused_fields = ^{st_data, mem_en};

    // Select and extend the addressed byte/half; halfword ignores a[0].
    function automatic logic [31:0] load_align(input logic [31:0] rd,
                                               input logic [1:0]  a,
                                               input logic [4:0]  op);
        logic [31:0] sh;
        logic [15:0] half;
        sh   = rd >> {a, 3'b000};
        half = a[1] ? rd[31:16] : rd[15:0];
        if (op[4])      return {{24{sh[7]}}, sh[7:0]};
        else if (op[1]) return {24'h0, sh[7:0]};
        else if (op[3]) return {{16{half[15]}}, half};
        else if (op[0]) return {16'h0, half};
        else            return rd;
    endfunction

    assign flush           = ertn_flush | wb_ex;
    assign MEM_allowin     = ~mem_valid_q | WB_allowin;
    assign MEM_to_WB_valid = mem_valid_q;
    assign entry           = EXE_to_MEM_valid & MEM_allowin;

    always_comb begin
        mem_valid_d  = mem_valid_q;
        bus_d        = bus_q;
        first_d      = entry;
        hold_vld_d   = hold_vld_q;
        rdata_hold_d = rdata_hold_q;
        if (flush)
            mem_valid_d = 1'b0;
        else if (MEM_allowin)
            mem_valid_d = EXE_to_MEM_valid;
        // The bus still loads under a flush; MEM_valid keeps it harmless.
        if (entry)
            bus_d = EXE_to_MEM_BUS;
        // SRAM data is only live in the first cycle; capture it if WB stalls.
        // A new entry drops the hold so it can never leak into a younger load.
        if (entry | flush)
            hold_vld_d = 1'b0;
        else if (first_q & mem_valid_q & ~WB_allowin) begin
            hold_vld_d   = 1'b1;
            rdata_hold_d = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_q <= 1'b0;
            bus_q       <= '0;
            first_q     <= 1'b0;
            hold_vld_q  <= 1'b0;
        end else begin
            mem_valid_q <= mem_valid_d;
            bus_q       <= bus_d;
            first_q     <= first_d;
            hold_vld_q  <= hold_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        rdata_hold_q <= rdata_hold_d;
    end

    assign rdata        = hold_vld_q ? rdata_hold_q : data_sram_rdata;
    assign load_value   = load_align(rdata, exe_result[1:0], load_op);
    assign final_result = rfrom_mem ? load_value : exe_result;

    assign mem_ex   = mem_valid_q & ex;
    assign mem_ertn = mem_valid_q & inst_ertn;

    assign MEM_to_WB_BUS = {pc, gr_we, dest, final_result, csr_num, csr_we,
                            csr_wvalue, csr_wmask, ex, ex_code, inst_ertn};
    assign MEM_RF_BUS    = {dest & {5{gr_we & mem_valid_q}}, rfrom_mem, final_result,
                            mem_valid_q, csr_we, csr_num};

`ifdef MEM_PERF_CNT_EN
    logic [31:0] ld_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ld_cnt_q    <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (mem_valid_q & rfrom_mem & ~ex & WB_allowin)
                ld_cnt_q <= ld_cnt_q + 32'd1;
            if (mem_valid_q & rfrom_mem & ~WB_allowin)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_ld_cnt    = ld_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_ld_cnt    = 32'h0;
    assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam logic [4:0] LD_B  = 5'b10000;
    localparam logic [4:0] LD_H  = 5'b01000;
    localparam logic [4:0] LD_W  = 5'b00100;
    localparam logic [4:0] LD_BU = 5'b00010;
    localparam logic [4:0] LD_HU = 5'b00001;

    logic         clk = 1'b0;
    logic         resetn;
    logic [204:0] EXE_to_MEM_BUS;
    logic         EXE_to_MEM_valid;
    logic         MEM_allowin;
    logic         WB_allowin;
    logic         MEM_to_WB_valid;
    logic [165:0] MEM_to_WB_BUS;
    logic [53:0]  MEM_RF_BUS;
    logic [31:0]  data_sram_rdata;
    logic         mem_ex, mem_ertn;
    logic         ertn_flush, wb_ex;
    logic [31:0]  perf_ld_cnt, perf_stall_cnt;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .EXE_to_MEM_BUS   (EXE_to_MEM_BUS),
        .EXE_to_MEM_valid (EXE_to_MEM_valid),
        .MEM_allowin      (MEM_allowin),
        .WB_allowin       (WB_allowin),
        .MEM_to_WB_valid  (MEM_to_WB_valid),
        .MEM_to_WB_BUS    (MEM_to_WB_BUS),
        .MEM_RF_BUS       (MEM_RF_BUS),
        .data_sram_rdata  (data_sram_rdata),
        .mem_ex           (mem_ex),
        .mem_ertn         (mem_ertn),
        .ertn_flush       (ertn_flush),
        .wb_ex            (wb_ex),
        .perf_ld_cnt      (perf_ld_cnt),
        .perf_stall_cnt   (perf_stall_cnt)
    );

    typedef struct {
        logic [31:0] fin;
        logic [14:0] code;
        logic        ex;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Execute bus: gr_we=1, dest=3, csr_num=5, mem_en follows rfrom_mem.
    function automatic logic [204:0] mk_bus(input logic [31:0] pc, input logic [31:0] res,
                                            input logic [4:0] op, input logic rfm,
                                            input logic ex, input logic [14:0] code,
                                            input logic ertn);
        mk_bus = {pc, 1'b1, 5'd3, res, 32'hCAFE0000, rfm, op, rfm,
                  14'h005, 1'b0, 32'h0, 32'h0, ex, code, ertn};
    endfunction

    // Reference load result.
    function automatic logic [31:0] model(input logic [4:0] op, input logic rfm,
                                          input logic [31:0] addr, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (addr[1:0])
            2'd0: b = rd[7:0];
            2'd1: b = rd[15:8];
            2'd2: b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = (addr[1] == 1'b1) ? rd[31:16] : rd[15:0];
        if (!rfm)          model = addr;
        else if (op == LD_B)  model = {{24{b[7]}}, b};
        else if (op == LD_BU) model = {24'h0, b};
        else if (op == LD_H)  model = {{16{h[15]}}, h};
        else if (op == LD_HU) model = {16'h0, h};
        else                  model = rd;
    endfunction

    // Scoreboard: every transfer to writeback pops one expected entry.
    always @(negedge clk) begin
        if (resetn && MEM_to_WB_valid && WB_allowin) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_transfer: got final=%h, expected no transfer", MEM_to_WB_BUS[127:96]);
            end else begin
                mon_e = sb.pop_front();
                if (MEM_to_WB_BUS[127:96] !== mon_e.fin || MEM_to_WB_BUS[15:1] !== mon_e.code ||
                    MEM_to_WB_BUS[16] !== mon_e.ex) begin
                    errors++;
                    $display("FAIL wb_transfer: got final=%h ex=%b code=%h, expected final=%h ex=%b code=%h",
                             MEM_to_WB_BUS[127:96], MEM_to_WB_BUS[16], MEM_to_WB_BUS[15:1],
                             mon_e.fin, mon_e.ex, mon_e.code);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Called at posedge+1: present one entry for one edge.
    task automatic issue(input logic [204:0] bus, input logic push, input logic [31:0] fin,
                         input logic [14:0] code, input logic ex);
        EXE_to_MEM_BUS   = bus;
        EXE_to_MEM_valid = 1'b1;
        if (push) sb.push_back('{fin, code, ex});
        @(posedge clk); #1;
        EXE_to_MEM_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; EXE_to_MEM_BUS = '0; EXE_to_MEM_valid = 1'b0; WB_allowin = 1'b1;
        data_sram_rdata = 32'h0; ertn_flush = 1'b0; wb_ex = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (MEM_to_WB_valid !== 1'b0 || MEM_allowin !== 1'b1) begin
            errors++; $display("FAIL reset_hs: got valid=%b allowin=%b, expected 0 1", MEM_to_WB_valid, MEM_allowin);
        end
        checks++;
        if (MEM_to_WB_BUS !== '0 || MEM_RF_BUS !== '0 || mem_ex !== 1'b0 || mem_ertn !== 1'b0) begin
            errors++; $display("FAIL reset_bus: got wb=%h rf=%h ex=%b ertn=%b, expected all 0",
                               MEM_to_WB_BUS, MEM_RF_BUS, mem_ex, mem_ertn);
        end
        checks++;
        if (perf_ld_cnt !== 32'h0 || perf_stall_cnt !== 32'h0) begin
            errors++; $display("FAIL reset_perf: got %0d %0d, expected 0 0", perf_ld_cnt, perf_stall_cnt);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_ld_w();
        issue(mk_bus(32'h1C000000, 32'h1000, LD_W, 1'b1, 1'b0, 15'h0, 1'b0), 1'b1, 32'hDEADBEEF, 15'h0, 1'b0);
        data_sram_rdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (MEM_to_WB_valid !== 1'b1) begin
            errors++; $display("FAIL ldw_valid: got %b, expected 1", MEM_to_WB_valid);
        end
        checks++;
        if (MEM_RF_BUS !== {5'd3, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 14'h005}) begin
            errors++; $display("FAIL ldw_fwd: got %h, expected %h", MEM_RF_BUS,
                               {5'd3, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 14'h005});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_align();
        logic [4:0]  ops [7] = '{LD_B, LD_BU, LD_HU, LD_H, LD_H, LD_B, 5'b00000};
        logic [31:0] adr [7] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1001, 32'h1001, 32'h55AA1234};
        logic [31:0] rds [7] = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000,
                                 32'h00009ABC, 32'h00007F00, 32'hFFFFFFFF};
        logic        rfm;
        for (int i = 0; i < 7; i++) begin
            rfm = (ops[i] != 5'b00000);
            issue(mk_bus(32'h1C000100 + i*4, adr[i], ops[i], rfm, 1'b0, 15'h0, 1'b0),
                  1'b1, model(ops[i], rfm, adr[i], rds[i]), 15'h0, 1'b0);
            data_sram_rdata = rds[i];
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        issue(mk_bus(32'h1C000200, 32'h2000, LD_W, 1'b1, 1'b0, 15'h0, 1'b0), 1'b1, 32'h12345678, 15'h0, 1'b0);
        data_sram_rdata = 32'h12345678;
        WB_allowin = 1'b0;
        @(posedge clk); #1;
        data_sram_rdata = 32'h0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (MEM_to_WB_BUS[127:96] !== 32'h12345678 || MEM_to_WB_valid !== 1'b1 ||
                MEM_allowin !== 1'b0 || dut.hold_vld_q !== 1'b1) begin
                errors++; $display("FAIL stall_hold: got final=%h valid=%b allowin=%b hold=%b, expected 12345678 1 0 1",
                                   MEM_to_WB_BUS[127:96], MEM_to_WB_valid, MEM_allowin, dut.hold_vld_q);
            end
            @(posedge clk); #1;
        end
        WB_allowin = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        issue(mk_bus(32'h1C000300, 32'h3000, LD_W, 1'b1, 1'b0, 15'h0, 1'b0), 1'b1, 32'hAAAA5555, 15'h0, 1'b0);
        data_sram_rdata = 32'hAAAA5555;
        WB_allowin = 1'b0;
        @(posedge clk); #1;
        WB_allowin = 1'b1;
        data_sram_rdata = 32'h0BAD0BAD;
        issue(mk_bus(32'h1C000304, 32'h3004, LD_W, 1'b1, 1'b0, 15'h0, 1'b0), 1'b1, 32'h13572468, 15'h0, 1'b0);
        data_sram_rdata = 32'h13572468;
        @(negedge clk);
        checks++;
        if (dut.hold_vld_q !== 1'b0) begin
            errors++; $display("FAIL b2b_hold: got %b, expected 0", dut.hold_vld_q);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        wb_ex = 1'b1;
        issue(mk_bus(32'h1C000400, 32'h4000, LD_W, 1'b1, 1'b0, 15'h0, 1'b0), 1'b0, 32'h0, 15'h0, 1'b0);
        wb_ex = 1'b0;
        data_sram_rdata = 32'h99999999;
        @(negedge clk);
        checks++;
        if (MEM_to_WB_valid !== 1'b0 || MEM_allowin !== 1'b1 || dut.hold_vld_q !== 1'b0) begin
            errors++; $display("FAIL flush_entry: got valid=%b allowin=%b hold=%b, expected 0 1 0",
                               MEM_to_WB_valid, MEM_allowin, dut.hold_vld_q);
        end
        @(posedge clk); #1;
        issue(mk_bus(32'h1C000404, 32'h4004, LD_W, 1'b1, 1'b0, 15'h0, 1'b0), 1'b0, 32'h0, 15'h0, 1'b0);
        WB_allowin = 1'b0;
        @(posedge clk); #1;
        ertn_flush = 1'b1;
        @(posedge clk); #1;
        ertn_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (MEM_to_WB_valid !== 1'b0 || dut.hold_vld_q !== 1'b0) begin
            errors++; $display("FAIL flush_held: got valid=%b hold=%b, expected 0 0", MEM_to_WB_valid, dut.hold_vld_q);
        end
        WB_allowin = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ex();
        issue(mk_bus(32'h1C000500, 32'h5000, 5'b0, 1'b0, 1'b1, 15'h0008, 1'b0), 1'b1, 32'h5000, 15'h0008, 1'b1);
        @(negedge clk);
        checks++;
        if (mem_ex !== 1'b1 || mem_ertn !== 1'b0 || MEM_to_WB_BUS[15:1] !== 15'h0008) begin
            errors++; $display("FAIL ex_status: got ex=%b ertn=%b code=%h, expected 1 0 0008",
                               mem_ex, mem_ertn, MEM_to_WB_BUS[15:1]);
        end
        @(posedge clk); #1;
        issue(mk_bus(32'h1C000504, 32'h5004, 5'b0, 1'b0, 1'b0, 15'h0, 1'b1), 1'b1, 32'h5004, 15'h0, 1'b0);
        @(negedge clk);
        checks++;
        if (mem_ertn !== 1'b1 || mem_ex !== 1'b0 || MEM_to_WB_BUS[0] !== 1'b1) begin
            errors++; $display("FAIL ertn_status: got ertn=%b ex=%b bus=%b, expected 1 0 1",
                               mem_ertn, mem_ex, MEM_to_WB_BUS[0]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (mem_ertn !== 1'b0 || mem_ex !== 1'b0) begin
            errors++; $display("FAIL status_empty: got ertn=%b ex=%b, expected 0 0", mem_ertn, mem_ex);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_perf();
        logic [31:0] exp_ld, exp_st;
`ifdef MEM_PERF_CNT_EN
        exp_ld = 32'd2; exp_st = 32'd1;
`else
        exp_ld = 32'd0; exp_st = 32'd0;
`endif
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        issue(mk_bus(32'h1C000600, 32'h6000, LD_W, 1'b1, 1'b0, 15'h0, 1'b0), 1'b1, 32'h11111111, 15'h0, 1'b0);
        data_sram_rdata = 32'h11111111;
        issue(mk_bus(32'h1C000604, 32'h6004, LD_W, 1'b1, 1'b0, 15'h0, 1'b0), 1'b1, 32'h22222222, 15'h0, 1'b0);
        data_sram_rdata = 32'h22222222;
        WB_allowin = 1'b0;
        @(posedge clk); #1;
        WB_allowin = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (perf_ld_cnt !== exp_ld || perf_stall_cnt !== exp_st) begin
            errors++; $display("FAIL perf_cnt: got ld=%0d stall=%0d, expected ld=%0d stall=%0d",
                               perf_ld_cnt, perf_stall_cnt, exp_ld, exp_st);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_ld_w();
        test_align();
        test_stall();
        test_back_to_back();
        test_flush();
        test_ex();
        test_perf();
        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
